data_bus_arbiter: RTL and testbench

Shares the single data bus (`avalon_bus`) between up to four bus masters: the processor data port plus auxiliary masters such as a memory loader or DMA engine. Requests are granted round-robin, one transaction at a time. The granted master's address, data and strobe are forwarded to the bus, and the bus completion is returned to that master only. A timeout guard keeps a hung slave from locking the bus. The block sits in `de1soc_top` between the masters and `avalon_bus`.

---
 rtl/data_bus_arbiter_pkg.sv | 16 +
 rtl/data_bus_arbiter_if.sv | 37 +++
 rtl/data_bus_arbiter_rr_picker.sv | 28 ++
 rtl/data_bus_arbiter.sv | 132 +++++++++++++
 tb/tb_data_bus_arbiter.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_bus_arbiter_pkg.sv
// Shared types and constants for the data bus arbiter.
//   arb_state_t  : arbiter FSM states
//   BUS_ERR_DATA : read data returned to a master whose transaction timed out
//   MAX_MASTERS  : largest supported number of bus masters
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic [15:0] BUS_ERR_DATA = 16'hDEAD;
  localparam int          MAX_MASTERS  = 4;

endpackage

// File: rtl/data_bus_arbiter_if.sv
// Master-side and bus-side signal bundle of the data bus arbiter.
//   MRead/MWrite      : per-master request strobes (held until MDone)
//   MAddr/MDataOut    : per-master address and write data
//   MDataIn           : read data shared by all masters
//   MDone/MErr        : per-master completion pulse and timeout flag
//   BusRead/BusWrite  : strobes towards avalon_bus
//   BusAddr/BusDataOut: address and write data towards avalon_bus
//   BusDataIn/BusDone : read data and completion pulse from avalon_bus
// modport slave  : the arbiter's view
// modport master : the view of the masters and the bus that surround it
interface data_bus_arbiter_if #(
  parameter int N = 2
);
  logic [N-1:0]       MRead;
  logic [N-1:0]       MWrite;
  logic [N-1:0][15:0] MAddr;
  logic [N-1:0][15:0] MDataOut;
  logic [15:0]        MDataIn;
  logic [N-1:0]       MDone;
  logic [N-1:0]       MErr;
  logic               BusRead;
  logic               BusWrite;
  logic [15:0]        BusAddr;
  logic [15:0]        BusDataOut;
  logic [15:0]        BusDataIn;
  logic               BusDone;

  modport slave (
    input  MRead, MWrite, MAddr, MDataOut, BusDataIn, BusDone,
    output MDataIn, MDone, MErr, BusRead, BusWrite, BusAddr, BusDataOut
  );

  modport master (
    output MRead, MWrite, MAddr, MDataOut, BusDataIn, BusDone,
    input  MDataIn, MDone, MErr, BusRead, BusWrite, BusAddr, BusDataOut
  );
endinterface

// File: rtl/data_bus_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   req   : request vector, one bit per master
//   last  : index of the most recently served master
//   grant : first requesting index after last (wrapping mod N)
//   valid : at least one master is requesting
module rr_picker #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [$clog2(N)-1:0] grant,
  output logic                 valid
);
  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] cand_s;

  // Scan candidates from farthest to nearest so the nearest requester after last wins.
  always_comb begin
    grant  = last;
    cand_s = last;
    for (int k = N; k >= 1; k--) begin
      cand_s = IDX_W'((int'(last) + k) % N);
      grant  = req[cand_s] ? cand_s : grant;
    end
    valid = |req;
  end
endmodule

// File: rtl/data_bus_arbiter.sv
// Round-robin arbiter sharing one data bus between N masters, one
// transaction at a time, with a timeout guard against hung slaves.
//   Clock  : system clock, rising edge
//   Reset  : asynchronous active-low reset
//   bus_if : master requests/responses and avalon_bus strobes (slave modport)
// The interface instance must be built with the same N as this module.
module data_bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int N       = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic              Clock,
  input  logic              Reset,
  data_bus_arbiter_if.slave bus_if
);
  localparam int               IDX_W    = $clog2(N);
  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [N-1:0]     ONE_N    = {{(N-1){1'b0}}, 1'b1};

  arb_state_t       state_r;
  logic [IDX_W-1:0] last_r;
  logic [IDX_W-1:0] grant_r;
  logic [15:0]      addr_r;
  logic [15:0]      wdata_r;
  logic             bus_read_r;
  logic             bus_write_r;
  logic [CNT_W-1:0] cnt_r;
  logic [15:0]      mdata_in_r;
  logic [N-1:0]     mdone_r;
  logic [N-1:0]     merr_r;

  logic [N-1:0]     req_s;
  logic [IDX_W-1:0] pick_grant_s;
  logic             pick_valid_s;
  logic [N-1:0]     grant_oh_s;

  assign req_s      = bus_if.MRead | bus_if.MWrite;
  assign grant_oh_s = ONE_N << grant_r;

  rr_picker #(.N(N)) u_picker (
    .req   (req_s),
    .last  (last_r),
    .grant (pick_grant_s),
    .valid (pick_valid_s)
  );

  // Arbitration FSM: grant capture, bus strobes, timeout and completion pulse.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_r     <= IDLE;
      last_r      <= IDX_W'(N - 1);
      grant_r     <= '0;
      addr_r      <= 16'h0000;
      wdata_r     <= 16'h0000;
      bus_read_r  <= 1'b0;
      bus_write_r <= 1'b0;
      cnt_r       <= '0;
      mdata_in_r  <= 16'h0000;
      mdone_r     <= '0;
      merr_r      <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          mdone_r <= '0;
          merr_r  <= '0;
          if (pick_valid_s) begin
            grant_r     <= pick_grant_s;
            addr_r      <= bus_if.MAddr[pick_grant_s];
            wdata_r     <= bus_if.MDataOut[pick_grant_s];
            // A master raising both strobes gets a write; the read is dropped.
            bus_write_r <= bus_if.MWrite[pick_grant_s];
            bus_read_r  <= ~bus_if.MWrite[pick_grant_s];
            cnt_r       <= '0;
            state_r     <= WAIT;
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT: begin
          cnt_r <= cnt_r + CNT_W'(1);
          if (bus_if.BusDone) begin
            // Writes leave the shared read-data register untouched.
            if (bus_read_r) begin
              mdata_in_r <= bus_if.BusDataIn;
            end else begin
              mdata_in_r <= mdata_in_r;
            end
            bus_read_r  <= 1'b0;
            bus_write_r <= 1'b0;
            mdone_r     <= grant_oh_s;
            merr_r      <= '0;
            last_r      <= grant_r;
            state_r     <= RESP;
          end else if (cnt_r == CNT_LAST) begin
            // This edge is the TIMEOUT-th WAIT edge without completion.
            mdata_in_r  <= BUS_ERR_DATA;
            bus_read_r  <= 1'b0;
            bus_write_r <= 1'b0;
            mdone_r     <= grant_oh_s;
            merr_r      <= grant_oh_s;
            last_r      <= grant_r;
            state_r     <= RESP;
          end else begin
            state_r <= WAIT;
          end
        end
        RESP: begin
          mdone_r <= '0;
          merr_r  <= '0;
          state_r <= IDLE;
        end
        default: begin
          bus_read_r  <= 1'b0;
          bus_write_r <= 1'b0;
          mdone_r     <= '0;
          merr_r      <= '0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus_if.BusRead    = bus_read_r;
  assign bus_if.BusWrite   = bus_write_r;
  assign bus_if.BusAddr    = addr_r;
  assign bus_if.BusDataOut = wdata_r;
  assign bus_if.MDataIn    = mdata_in_r;
  assign bus_if.MDone      = mdone_r;
  assign bus_if.MErr       = merr_r;
endmodule

// File: tb/tb_data_bus_arbiter.sv
// Testbench for data_bus_arbiter: directed scenarios plus random traffic,
// with a bus-slave model, a round-robin reference and a completion scoreboard.
module tb_data_bus_arbiter;
  localparam int N       = 3;
  localparam int TIMEOUT = 8;

  typedef struct {
    int          master;
    bit          err;
    logic [15:0] data;
  } exp_t;

  logic Clock;
  logic Reset;

  data_bus_arbiter_if #(.N(N)) bus_if ();

  data_bus_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .bus_if (bus_if)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int          tests = 0;
  int          fails = 0;
  exp_t        sb_q[$];
  exp_t        mon_e;

  logic [N-1:0] m_rd;
  logic [N-1:0] m_wr;
  logic [15:0]  m_addr [N];
  logic [15:0]  m_data [N];

  int          last_m;
  logic [15:0] mdin_m;

  bit          busy;
  int          bcnt;
  int          bdelay;
  int          strobe_len;
  logic [15:0] brdata;
  logic [15:0] cap_addr;
  logic [15:0] cap_data;
  logic        cap_rd;
  logic        cap_wr;

  bit          f_use;
  int          f_delay;
  logic [15:0] f_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin reference: first requester after the last served master.
  function automatic int rr_pick(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic drive();
    bus_if.MRead  = m_rd;
    bus_if.MWrite = m_wr;
    for (int i = 0; i < N; i++) begin
      bus_if.MAddr[i]    = m_addr[i];
      bus_if.MDataOut[i] = m_data[i];
    end
  endtask

  task automatic model_reset();
    last_m         = N - 1;
    mdin_m         = 16'h0000;
    busy           = 1'b0;
    bus_if.BusDone = 1'b0;
  endtask

  // One clock: drive masters, then play the bus slave and release finished masters.
  task automatic step();
    logic [N-1:0] req_now;
    logic         strobe;
    int           g;
    exp_t         e;
    drive();
    @(posedge Clock);
    #1;
    req_now        = m_rd | m_wr;
    strobe         = bus_if.BusRead | bus_if.BusWrite;
    bus_if.BusDone = 1'b0;
    if (!busy && strobe) begin
      g = rr_pick(req_now, last_m);
      check("grant_has_request", (g >= 0) ? 32'd1 : 32'd0, 32'd1);
      if (g >= 0) begin
        cap_addr = m_addr[g];
        cap_data = m_data[g];
        cap_wr   = m_wr[g];
        cap_rd   = m_rd[g] & ~m_wr[g];
        last_m   = g;
        if (f_use) begin
          bdelay = f_delay;
          brdata = f_data;
          f_use  = 1'b0;
        end else begin
          bdelay = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
          brdata = 16'($urandom);
        end
        if (bdelay < 0) mdin_m = 16'hDEAD;
        else if (cap_rd) mdin_m = brdata;
        e.master = g;
        e.err    = (bdelay < 0);
        e.data   = mdin_m;
        sb_q.push_back(e);
        busy       = 1'b1;
        bcnt       = 0;
        strobe_len = 0;
      end
    end
    if (busy) begin
      if (strobe) begin
        strobe_len++;
        check("bus_addr", 32'(bus_if.BusAddr), 32'(cap_addr));
        check("bus_data_out", 32'(bus_if.BusDataOut), 32'(cap_data));
        check("bus_write", 32'(bus_if.BusWrite), 32'(cap_wr));
        check("bus_read", 32'(bus_if.BusRead), 32'(cap_rd));
        if (bdelay >= 0 && bcnt == bdelay) begin
          bus_if.BusDone   = 1'b1;
          bus_if.BusDataIn = brdata;
        end
        bcnt++;
      end else begin
        check("strobe_cycles", 32'(strobe_len), (bdelay < 0) ? 32'(TIMEOUT) : 32'(bdelay + 1));
        busy = 1'b0;
        if (bdelay < 0) begin
          // Late completion after a timeout; the arbiter must ignore it.
          bus_if.BusDone   = 1'b1;
          bus_if.BusDataIn = 16'($urandom);
        end
      end
    end
    for (int m = 0; m < N; m++) begin
      if (bus_if.MDone[m]) begin
        m_rd[m] = 1'b0;
        m_wr[m] = 1'b0;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || sb_q.size() != 0 || (m_rd | m_wr) != '0) && n < 60) begin
      step();
      n++;
    end
    check(name, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic pulse_reset();
    Reset = 1'b0;
    model_reset();
    step();
    Reset = 1'b1;
  endtask

  // Scoreboard monitor: one expectation consumed per completion pulse.
  always @(posedge Clock) begin
    #1;
    if (Reset === 1'b1) begin
      if (bus_if.MDone != '0) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'(bus_if.MDone), 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("done_master", 32'(bus_if.MDone), 32'd1 << mon_e.master);
          check("err_flag", 32'(bus_if.MErr), mon_e.err ? (32'd1 << mon_e.master) : 32'd0);
          check("mdata_in", 32'(bus_if.MDataIn), 32'(mon_e.data));
        end
      end else if (bus_if.MErr != '0) begin
        check("err_without_done", 32'(bus_if.MErr), 32'd0);
      end
    end
  end

  initial begin
    Reset            = 1'b0;
    m_rd             = '0;
    m_wr             = '0;
    for (int i = 0; i < N; i++) begin
      m_addr[i] = 16'h0000;
      m_data[i] = 16'h0000;
    end
    bus_if.BusDataIn = 16'h0000;
    f_use            = 1'b0;
    f_delay          = 0;
    f_data           = 16'h0000;
    model_reset();
    drive();

    // Reset state.
    repeat (2) @(posedge Clock);
    #1;
    check("rst_bus_read", 32'(bus_if.BusRead), 32'd0);
    check("rst_bus_write", 32'(bus_if.BusWrite), 32'd0);
    check("rst_bus_addr", 32'(bus_if.BusAddr), 32'd0);
    check("rst_bus_data_out", 32'(bus_if.BusDataOut), 32'd0);
    check("rst_mdata_in", 32'(bus_if.MDataIn), 32'd0);
    check("rst_mdone", 32'(bus_if.MDone), 32'd0);
    check("rst_merr", 32'(bus_if.MErr), 32'd0);
    Reset = 1'b1;
    step();
    check("idle_no_strobe", 32'(bus_if.BusRead | bus_if.BusWrite), 32'd0);

    // Master 0 reads 0x0040, bus answers 0x1234 after two extra cycles.
    m_rd[0] = 1'b1; m_addr[0] = 16'h0040; m_data[0] = 16'h0A0A;
    f_use = 1'b1; f_delay = 2; f_data = 16'h1234;
    wait_idle("read_0040");

    // Masters 0 and 1 together from reset, then a second pair.
    pulse_reset();
    m_rd[0] = 1'b1; m_addr[0] = 16'h0011; m_data[0] = 16'h1111;
    m_wr[1] = 1'b1; m_addr[1] = 16'h4022; m_data[1] = 16'h2222;
    f_use = 1'b1; f_delay = 0; f_data = 16'h3333;
    wait_idle("pair_first");
    m_rd[0] = 1'b1; m_addr[0] = 16'h0033;
    m_rd[1] = 1'b1; m_addr[1] = 16'h4044;
    wait_idle("pair_second");

    // Master 1 writes 0xBEEF to 0x0100 and changes its inputs mid-WAIT.
    m_wr[1] = 1'b1; m_addr[1] = 16'h0100; m_data[1] = 16'hBEEF;
    f_use = 1'b1; f_delay = 4; f_data = 16'h0000;
    step(); step();
    m_addr[1] = 16'hFFFF; m_data[1] = 16'h0000;
    wait_idle("addr_hold");

    // Hung slave: master 2 reads and the bus never completes.
    m_rd[2] = 1'b1; m_addr[2] = 16'h8123; m_data[2] = 16'h0000;
    f_use = 1'b1; f_delay = -1; f_data = 16'h0000;
    wait_idle("timeout");

    // Read and write raised together: only the write reaches the bus.
    m_rd[1] = 1'b1; m_wr[1] = 1'b1; m_addr[1] = 16'h4555; m_data[1] = 16'h5A5A;
    wait_idle("rd_wr_both");

    // Reset asserted in WAIT, then master 0 restarts.
    m_rd[0] = 1'b1; m_addr[0] = 16'h0222; m_data[0] = 16'h0000;
    f_use = 1'b1; f_delay = 5; f_data = 16'h5555;
    step(); step(); step();
    #2 Reset = 1'b0;
    #1;
    check("rst_wait_bus_read", 32'(bus_if.BusRead), 32'd0);
    check("rst_wait_bus_write", 32'(bus_if.BusWrite), 32'd0);
    check("rst_wait_mdone", 32'(bus_if.MDone), 32'd0);
    if (sb_q.size() > 0) sb_q.delete(sb_q.size() - 1);
    model_reset();
    step(); step();
    #2 Reset = 1'b1;
    wait_idle("reset_restart");

    // Random traffic from all masters.
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int m = 0; m < N; m++) begin
        if (m_rd[m] == 1'b0 && m_wr[m] == 1'b0 && $urandom_range(0, 3) == 0) begin
          int op;
          op        = int'($urandom_range(0, 2));
          m_addr[m] = {2'(m), 14'($urandom)};
          m_data[m] = 16'($urandom);
          m_rd[m]   = (op != 1);
          m_wr[m]   = (op != 0);
        end
      end
      step();
    end
    wait_idle("random_drain");
    check("bus_idle_end", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
